// File: rtl/bit_grid_viewer.sv
// Memory-dump overlay: renders RAM words as coloured bit cells with a row-label column and a
// column-index header row. The colour pipeline depth tracks the external RAM read latency.
module bit_grid_viewer #(
    parameter int         DATA_W  = 8,
    parameter int         COLS    = 16,
    parameter int         ROWS    = 64,
    parameter int         ADDR_W  = 10,
    parameter int         CELL_SH = 3,
    parameter int         RD_LAT  = 1,
    parameter int         CNT_W   = 11,
    parameter logic [2:0] FG      = 3'b110,
    parameter logic [2:0] BG      = 3'b001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  counter_x,
    input  logic [CNT_W-1:0]  counter_y,
    input  logic              in_display_area,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              base_valid,
    output logic              base_ready,
    input  logic              cursor_en,
    input  logic [ADDR_W-1:0] cursor_addr,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic              vga_r,
    output logic              vga_g,
    output logic              vga_b
);

    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int COL_SH = $clog2(COLS);
    localparam int BY_W   = CNT_W - CELL_SH;

    logic [BIT_W-1:0]           bitCnt_q, bitCnt_d, bitCur;
    logic [CNT_W-1:0]           grpCnt_q, grpCnt_d, grpCur;
    logic [BY_W-1:0]            cellY, rowIdx;
    logic [ADDR_W-1:0]          activeBase_q, pendBase_q, ramAddr_q, wordAddr;
    logic                       pending_q, ramEn_q, frameStart;
    logic                       black, headerRow, labelCol, readCell, cursorHit;
    logic [DATA_W-1:0]          labelVal, labelShift, dataShift;
    logic [2:0]                 colourPre, colourOut, vga_q, vga_d;
    logic [RD_LAT:0]            pRead_q, pHit_q, pDe_q;
    logic [RD_LAT:0][BIT_W-1:0] pBit_q;
    logic [RD_LAT:0][2:0]       pColour_q;

    // Running bit/group counters stand in for bx % (DATA_W+1) and bx / (DATA_W+1).
    always_comb begin
        bitCur   = (counter_x == '0) ? '0 : bitCnt_q;
        grpCur   = (counter_x == '0) ? '0 : grpCnt_q;
        bitCnt_d = bitCur;
        grpCnt_d = grpCur;
        if (&counter_x[CELL_SH-1:0]) begin
            if (bitCur == BIT_W'(DATA_W)) begin
                bitCnt_d = '0;
                grpCnt_d = grpCur + CNT_W'(1);
            end else begin
                bitCnt_d = bitCur + BIT_W'(1);
            end
        end
    end

    always_comb begin
        frameStart = (counter_x == '0) && (counter_y == '0);
        cellY      = counter_y[CNT_W-1:CELL_SH];
        rowIdx     = (cellY >> 1) - BY_W'(1);
        headerRow  = (cellY == '0);
        labelCol   = (grpCur == '0);
        black      = (counter_x[CELL_SH-1:0] == '0) || (counter_y[CELL_SH-1:0] == '0) ||
                     (bitCur == BIT_W'(DATA_W)) || cellY[0] ||
                     (grpCur > CNT_W'(COLS)) || (cellY > BY_W'(2 * ROWS)) ||
                     (headerRow && labelCol);
        readCell   = !black && !headerRow && !labelCol;
        wordAddr   = activeBase_q + (ADDR_W'(rowIdx) << COL_SH) + ADDR_W'(grpCur - CNT_W'(1));
        cursorHit  = readCell && cursor_en && (wordAddr == cursor_addr);
        labelVal   = headerRow ? DATA_W'(grpCur - CNT_W'(1)) : DATA_W'(rowIdx);
        labelShift = labelVal << bitCur;
        colourPre  = black ? 3'b000 : (labelShift[DATA_W-1] ? FG : BG);
    end

    // Final stage: RAM words are resolved here, everything else was coloured at issue time.
    always_comb begin
        dataShift = ram_data << pBit_q[RD_LAT];
        colourOut = pColour_q[RD_LAT];
        if (pRead_q[RD_LAT]) begin
            colourOut = dataShift[DATA_W-1] ? FG : BG;
            if (pHit_q[RD_LAT]) begin
                colourOut = ~colourOut;
            end
        end
        vga_d = colourOut & {3{pDe_q[RD_LAT]}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitCnt_q     <= '0;
            grpCnt_q     <= '0;
            activeBase_q <= '0;
            pendBase_q   <= '0;
            pending_q    <= 1'b0;
            ramEn_q      <= 1'b0;
            ramAddr_q    <= '0;
            pRead_q      <= '0;
            pHit_q       <= '0;
            pDe_q        <= '0;
            pBit_q       <= '0;
            pColour_q    <= '0;
            vga_q        <= 3'b000;
        end else begin
            bitCnt_q  <= bitCnt_d;
            grpCnt_q  <= grpCnt_d;
            ramEn_q   <= readCell;
            if (readCell) begin
                ramAddr_q <= wordAddr;
            end
            pRead_q   <= {pRead_q[RD_LAT-1:0], readCell};
            pHit_q    <= {pHit_q[RD_LAT-1:0], cursorHit};
            pDe_q     <= {pDe_q[RD_LAT-1:0], in_display_area};
            pBit_q    <= {pBit_q[RD_LAT-1:0], bitCur};
            pColour_q <= {pColour_q[RD_LAT-1:0], colourPre};
            vga_q     <= vga_d;
            // A pending page only lands on a frame start, so the base never moves mid-frame.
            if (pending_q && frameStart) begin
                activeBase_q <= pendBase_q;
                pending_q    <= 1'b0;
            end else if (!pending_q && base_valid) begin
                pendBase_q <= base_addr;
                pending_q  <= 1'b1;
            end
        end
    end

    assign base_ready = !pending_q;
    assign ram_en     = ramEn_q;
    assign ram_addr   = ramAddr_q;
    assign vga_r      = vga_q[2];
    assign vga_g      = vga_q[1];
    assign vga_b      = vga_q[0];

endmodule

// File: tb/tb_bit_grid_viewer.sv
// Scoreboard bench for bit_grid_viewer: two instances (read latency 1 and 3) share the pixel
// stream; each checkpoint pushes expected values that a negedge monitor pops when they fall due.
module tb_bit_grid_viewer;

    typedef struct {
        int         x;
        int         kind;
        int         inst;
        logic [9:0] exp;
        string      name;
    } watch_t;

    typedef struct {
        int         due;
        int         kind;
        int         inst;
        logic [9:0] exp;
        string      name;
    } item_t;

    logic        clk;
    logic        rstN;
    logic [10:0] counterX, counterY;
    logic        inDisplay;
    logic [9:0]  baseAddr;
    logic        baseValid;
    logic        cursorEn;
    logic [9:0]  cursorAddr;
    logic        baseReady0, baseReady1;
    logic        ramEn0, ramEn1;
    logic [9:0]  ramAddr0, ramAddr1;
    logic [7:0]  ramData0, ramData1;
    logic        vgaR0, vgaG0, vgaB0, vgaR1, vgaG1, vgaB1;
    logic [7:0]  mem [0:1023];
    logic [9:0]  addrD1, addrD2;

    int     edgeCnt = 0;
    int     nVectors = 0;
    int     nMiscompares = 0;
    watch_t watchQ[$];
    item_t  sbQ[$];

    bit_grid_viewer #(.RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rstN), .counter_x(counterX), .counter_y(counterY),
        .in_display_area(inDisplay), .base_addr(baseAddr), .base_valid(baseValid),
        .base_ready(baseReady0), .cursor_en(cursorEn), .cursor_addr(cursorAddr),
        .ram_en(ramEn0), .ram_addr(ramAddr0), .ram_data(ramData0),
        .vga_r(vgaR0), .vga_g(vgaG0), .vga_b(vgaB0)
    );

    bit_grid_viewer #(.RD_LAT(3)) dut1 (
        .clk(clk), .rst_n(rstN), .counter_x(counterX), .counter_y(counterY),
        .in_display_area(inDisplay), .base_addr(baseAddr), .base_valid(baseValid),
        .base_ready(baseReady1), .cursor_en(cursorEn), .cursor_addr(cursorAddr),
        .ram_en(ramEn1), .ram_addr(ramAddr1), .ram_data(ramData1),
        .vga_r(vgaR1), .vga_g(vgaG1), .vga_b(vgaB1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Synchronous RAM models: data for the address seen at edge t+1 is valid after edge t+LAT.
    always @(posedge clk) ramData0 <= mem[ramAddr0];

    always @(posedge clk) begin
        addrD1   <= ramAddr1;
        addrD2   <= addrD1;
        ramData1 <= mem[addrD2];
    end

    function automatic logic [9:0] actualOf(input int kind, input int inst);
        logic [9:0] v;
        v = 'x;
        case (kind)
            0: v = (inst == 0) ? {7'd0, vgaR0, vgaG0, vgaB0} : {7'd0, vgaR1, vgaG1, vgaB1};
            1: v = (inst == 0) ? {9'd0, ramEn0} : {9'd0, ramEn1};
            2: v = (inst == 0) ? ramAddr0 : ramAddr1;
            default: v = (inst == 0) ? {9'd0, baseReady0} : {9'd0, baseReady1};
        endcase
        return v;
    endfunction

    task automatic checkOutput(input item_t it);
        logic [9:0] act;
        act = actualOf(it.kind, it.inst);
        nVectors++;
        if (act !== it.exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", it.name, act, it.exp);
        end
    endtask

    always @(negedge clk) begin
        int idx;
        idx = 0;
        while (idx < sbQ.size()) begin
            if (sbQ[idx].due == edgeCnt) begin
                checkOutput(sbQ[idx]);
                sbQ.delete(idx);
            end else begin
                idx++;
            end
        end
    end

    task automatic pushItem(input int due, input int kind, input int inst, input logic [9:0] exp,
                            input string name);
        item_t it;
        it.due  = due;
        it.kind = kind;
        it.inst = inst;
        it.exp  = exp;
        it.name = name;
        sbQ.push_back(it);
    endtask

    task automatic addWatch(input int x, input int kind, input int inst, input logic [9:0] exp,
                            input string name);
        watch_t w;
        w.x    = x;
        w.kind = kind;
        w.inst = inst;
        w.exp  = exp;
        w.name = name;
        watchQ.push_back(w);
    endtask

    task automatic addVga(input int x, input logic [2:0] exp, input string name);
        addWatch(x, 0, 0, {7'd0, exp}, {name, "/vga_lat1"});
        addWatch(x, 0, 1, {7'd0, exp}, {name, "/vga_lat3"});
    endtask

    task automatic addRam(input int x, input logic en, input logic [9:0] addr, input string name);
        addWatch(x, 1, 0, {9'd0, en}, {name, "/ram_en_lat1"});
        addWatch(x, 1, 1, {9'd0, en}, {name, "/ram_en_lat3"});
        if (en) begin
            addWatch(x, 2, 0, addr, {name, "/ram_addr_lat1"});
            addWatch(x, 2, 1, addr, {name, "/ram_addr_lat3"});
        end
    endtask

    task automatic addReady(input int x, input logic exp, input string name);
        addWatch(x, 3, 0, {9'd0, exp}, {name, "/ready_lat1"});
        addWatch(x, 3, 1, {9'd0, exp}, {name, "/ready_lat3"});
    endtask

    // Drives one pixel at the negedge; e is the index of the posedge that samples it.
    task automatic applyStimulus(input int x, input int y, input logic de, input logic valid,
                                 input logic [9:0] base, input logic rstVal, output int e);
        @(negedge clk);
        rstN      = rstVal;
        counterX  = 11'(x);
        counterY  = 11'(y);
        inDisplay = de;
        baseValid = valid;
        baseAddr  = base;
        e         = edgeCnt + 1;
    endtask

    task automatic runLine(input int y, input int xEnd, input int deOffX, input int validX,
                           input logic [9:0] baseVal);
        int e;
        int lat;
        for (int x = 0; x <= xEnd; x++) begin
            applyStimulus(x, y, (x != deOffX), (x == validX), baseVal, 1'b1, e);
            for (int i = 0; i < watchQ.size(); i++) begin
                if (watchQ[i].x == x) begin
                    lat = (watchQ[i].kind != 0) ? 0 : ((watchQ[i].inst == 0) ? 2 : 4);
                    pushItem(e + lat, watchQ[i].kind, watchQ[i].inst, watchQ[i].exp,
                             watchQ[i].name);
                end
            end
        end
        watchQ.delete();
    endtask

    initial begin
        int e;
        rstN       = 1'b0;
        counterX   = '0;
        counterY   = '0;
        inDisplay  = 1'b0;
        baseAddr   = '0;
        baseValid  = 1'b0;
        cursorEn   = 1'b0;
        cursorAddr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0]      = 8'hA5;
        mem[5]      = 8'h80;
        mem[6]      = 8'h80;
        mem[15]     = 8'h80;
        mem[10'h3F0] = 8'h00;

        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 1'b1, 1'b0, 10'h000, 1'b0, e);
            for (int k = 0; k < 2; k++) begin
                pushItem(e, 0, k, 10'h000, "reset vga");
                pushItem(e, 1, k, 10'h000, "reset ram_en");
                pushItem(e, 2, k, 10'h000, "reset ram_addr");
                pushItem(e, 3, k, 10'h001, "reset base_ready");
            end
        end
        applyStimulus(0, 0, 1'b1, 1'b0, 10'h000, 1'b1, e);
        pushItem(e + 2, 0, 0, 10'h000, "first pixel/lat1");
        pushItem(e + 4, 0, 1, 10'h000, "first pixel/lat3");

        addVga(9, 3'b001, "label k0");
        addRam(9, 1'b0, 10'h000, "label k0");
        addVga(73, 3'b110, "word0 bit7");
        addRam(73, 1'b1, 10'h000, "word0 bit7");
        addVga(81, 3'b001, "word0 bit6");
        addRam(81, 1'b1, 10'h000, "word0 bit6");
        runLine(17, 81, -1, -1, 10'h000);

        addVga(57, 3'b110, "label k5");
        runLine(97, 57, -1, -1, 10'h000);

        addVga(9, 3'b000, "header corner");
        addVga(288, 3'b000, "header gridline");
        addVga(289, 3'b001, "header g4 b0");
        addRam(289, 1'b0, 10'h000, "header g4 b0");
        addVga(345, 3'b110, "header g4 b7");
        addRam(345, 1'b0, 10'h000, "header g4 b7");
        addVga(353, 3'b000, "separator");
        runLine(3, 353, -1, -1, 10'h000);

        addVga(81, 3'b000, "spacer row");
        addRam(81, 1'b0, 10'h000, "spacer row");
        runLine(9, 81, -1, -1, 10'h000);

        addVga(73, 3'b000, "display off");
        addVga(1153, 3'b110, "last column");
        addRam(1153, 1'b1, 10'h00F, "last column");
        addVga(1225, 3'b000, "beyond cols");
        addRam(1225, 1'b0, 10'h000, "beyond cols");
        runLine(17, 1225, 73, -1, 10'h000);

        addVga(57, 3'b110, "label k63");
        addVga(73, 3'b001, "last row");
        addRam(73, 1'b1, 10'h3F0, "last row");
        runLine(1025, 73, -1, -1, 10'h000);

        addVga(73, 3'b000, "beyond rows");
        addRam(73, 1'b0, 10'h000, "beyond rows");
        runLine(1041, 73, -1, -1, 10'h000);

        cursorEn   = 1'b1;
        cursorAddr = 10'h005;
        addVga(9, 3'b001, "cursor label");
        addVga(433, 3'b001, "cursor fg");
        addRam(433, 1'b1, 10'h005, "cursor fg");
        addVga(441, 3'b110, "cursor bg");
        addVga(505, 3'b110, "cursor neighbour");
        addRam(505, 1'b1, 10'h006, "cursor neighbour");
        runLine(17, 510, -1, -1, 10'h000);
        cursorEn = 1'b0;

        addReady(4, 1'b1, "ready idle");
        addReady(5, 1'b0, "ready accepted");
        addReady(73, 1'b0, "ready pending");
        addRam(73, 1'b1, 10'h000, "base held");
        runLine(17, 81, -1, 5, 10'h3F0);

        addReady(0, 1'b1, "ready at frame start");
        runLine(0, 9, -1, -1, 10'h000);

        addVga(73, 3'b001, "new base k0");
        addRam(73, 1'b1, 10'h3F0, "new base k0");
        runLine(17, 73, -1, -1, 10'h000);

        addVga(73, 3'b110, "base wrap k1");
        addRam(73, 1'b1, 10'h000, "base wrap k1");
        runLine(33, 73, -1, -1, 10'h000);

        addReady(0, 1'b0, "accept on frame start");
        addReady(9, 1'b0, "pending after frame start");
        runLine(0, 9, -1, 0, 10'h010);

        addRam(73, 1'b1, 10'h3F0, "base unchanged");
        runLine(17, 73, -1, -1, 10'h000);

        addReady(0, 1'b1, "ready next frame");
        runLine(0, 3, -1, -1, 10'h000);

        addVga(73, 3'b001, "base 010");
        addRam(73, 1'b1, 10'h010, "base 010");
        runLine(17, 73, -1, -1, 10'h000);

        repeat (8) @(negedge clk);
        nVectors++;
        if (sbQ.size() != 0) begin
            nMiscompares++;
            $display("[TB] FAIL scoreboard drain: got %0d, expected 0 outstanding", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/bit_grid_viewer.md
Name: bit_grid_viewer

Overview:
- Parametrised memory-dump overlay renderer. Draws a grid of memory words as coloured bit cells, with a row-index label column and a column-index header row.
- Sits between the 1280x1024 sync generator (prefetch counters) and the VGA output pins.
- Drives the read port of an external synchronous debug RAM with configurable read latency.
- Adds over the fixed-width predecessor: a frame-synchronous page-base handshake, a cursor highlight, and generic word width, column count and cell size.

Parameters:
- DATA_W, 8: bits per RAM word; each field is DATA_W bit cells plus 1 separator cell.
- COLS, 16: data words per displayed row (power of 2).
- ROWS, 64: displayed data rows.
- ADDR_W, 10: RAM address width.
- CELL_SH, 3: cell size is 2^CELL_SH pixels square.
- RD_LAT, 1: RAM read latency in clocks (1..4).
- CNT_W, 11: width of the x/y counters.
- FG, 3'b110: colour for a 1 bit.
- BG, 3'b001: colour for a 0 bit.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- counter_x  in  CNT_W  prefetch pixel x; advances by 1 per clk within a line
- counter_y  in  CNT_W  pixel y
- in_display_area  in  1  pixel visible
- base_addr  in  ADDR_W  requested page base
- base_valid  in  1  base request
- base_ready  out  1  base request can be accepted
- cursor_en  in  1  cursor highlight enable
- cursor_addr  in  ADDR_W  word address to highlight
- ram_en  out  1  RAM read enable
- ram_addr  out  ADDR_W  RAM read address
- ram_data  in  DATA_W  RAM read data, valid RD_LAT clocks after ram_en
- vga_r, vga_g, vga_b  out  1 each  registered colour outputs

Behaviour:
- Reset: all of the following take effect on a clk edge with rst_n low. vga_* = 0, ram_en = 0, ram_addr = 0, active base = 0, pending flag = 0, base_ready = 1, all pipeline valid and read flags = 0. A reset mid-frame blanks output starting at the next edge.
- Cell coordinates: bx = counter_x >> CELL_SH, by = counter_y >> CELL_SH. Group g = bx / (DATA_W+1), bit index b = bx % (DATA_W+1).
- Division and modulo are realised with running group/bit counters cleared at counter_x == 0. No dividers.
- Black (3'b000) is output when any of the following holds:
  - low CELL_SH bits of counter_x or counter_y are 0 (grid lines);
  - b == DATA_W (separator cell);
  - by is odd (spacer row);
  - g > COLS;
  - by > 2*ROWS;
  - header row (by == 0) with g == 0.
- Header row (by == 0), g >= 1: show bit DATA_W-1-b of (g-1).
- Data row k = by/2 - 1, with 0 <= k < ROWS:
  - g == 0: show bit DATA_W-1-b of k, truncated or zero-extended to DATA_W.
  - g >= 1: address A = (active_base + k*COLS + g-1) mod 2^ADDR_W. Assert ram_en = 1 and ram_addr = A, both registered. Show bit DATA_W-1-b of ram_data.
- ram_en is 0 outside data cells. ram_addr holds its last value while ram_en = 0.
- Shown bits use FG for 1 and BG for 0.
- Cursor: for a data cell with cursor_en = 1 and A == cursor_addr, the colour is bitwise inverted. The label, header and black cells are never inverted.
- Latency:
  - Inputs sampled at edge t produce vga_* at edge t+RD_LAT+1, for every RD_LAT.
  - The pipeline carries the read flag, b, cursor hit, precomputed colour and in_display_area.
  - vga_* = colour AND the delayed in_display_area.
- Page handshake:
  - A request is accepted on an edge where base_valid and base_ready are both 1. The value is stored as pending and base_ready goes to 0.
  - At the next frame start strictly after acceptance (counter_x == 0 and counter_y == 0), active_base takes the pending value and base_ready returns to 1.
  - A request accepted on the frame-start edge itself applies at the following frame start.
  - active_base never changes mid-frame.

Test Plan:
1. rst_n=0 for 2 clk, then 1 with counter_x=0, counter_y=0 -> during reset vga=000, ram_en=0, base_ready=1; after release the first pixel is black (grid line).
2. Defaults, base=0, counter_x=81, counter_y=17, ram_data=8'hA5 returned 1 clk later -> ram_en=1, ram_addr=10'h000; vga=001 at t+2. With counter_x=73 the same word gives vga=110.
3. Header: counter_y=3, counter_x=345 -> 110; counter_x=289 -> 001; ram_en=0 at both pixels.
4. Black cases: counter_x=288, counter_x=353 (separator), counter_y=9 (spacer row), counter_x=1225 (g>COLS) -> 000; in_display_area=0 with an FG pixel -> 000.
5. Handshake: base_addr=10'h3F0 accepted mid-frame -> base_ready=0 and addresses unchanged until frame start. Next frame: k=0,g=1 reads 10'h3F0; k=1,g=1 reads 10'h000 (wrap); base_ready=1.
6. Cursor and latency with RD_LAT=3: cursor_addr=10'h005, cursor_en=1, data bit 1 at that word -> vga=001 (inverted), appearing at t+4. The word at 10'h006 shows normal colours.
